// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default reset PC
// and the branch-offset helper used by the next-PC unit.
package fetch_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_OUT  = 3'd2,
      S_RES  = 3'd3,
      S_HALT = 3'd4
   } state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

   // Branch offsets are in words; sign-extend and scale to a byte offset.
   function automatic logic [31:0] sext_word_off(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/fetch_seq_npc.sv
// Next-PC arithmetic: sequential, PC-relative branch, or pseudo-direct jump.
module fetch_seq_npc
   import fetch_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [15:0] imm16,
   input  logic [25:0] imm26,
   input  logic        branch,
   input  logic        jmp,
   output logic [31:0] npc
);

   logic [31:0] pc_4;

   // Jump takes the region bits from the current PC, not from pc+4.
   always_comb begin
      pc_4 = pc + 32'd4;
      if (jmp) begin
         npc = {pc[31:28], imm26, 2'b00};
      end else if (branch) begin
         npc = pc_4 + sext_word_off(imm16);
      end else begin
         npc = pc_4;
      end
   end

endmodule

// File: rtl/fetch_seq.sv
// Non-speculative fetch sequencer: one imem request in flight, hands the word to decode
// and waits for its branch/jump resolution before advancing the PC.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          TIMEOUT  = 16,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             inst_valid,
   input  logic             inst_ready,
   output logic [31:0]      inst,
   output logic [31:0]      inst_pc,
   input  logic             res_valid,
   input  logic             res_branch,
   input  logic             res_jmp,
   input  logic [15:0]      res_imm16,
   input  logic [25:0]      res_imm26,
   input  logic             res_halt,
   output logic             halted,
   output logic             fetch_err,
   output logic [CNT_W-1:0] retired,
   output logic [2:0]       dbg_state
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [31:0]         pc_q, pc_d;
   logic [31:0]         inst_q, inst_d;
   logic [31:0]         inst_pc_q, inst_pc_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic                err_q, err_d;
   logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
   logic                resolve;
   logic [31:0]         npc_w;

   fetch_seq_npc u_npc (
      .pc     (pc_q),
      .imm16  (res_imm16),
      .imm26  (res_imm26),
      .branch (res_branch),
      .jmp    (res_jmp),
      .npc    (npc_w)
   );

   // Handshakes: imem word is taken when imem_req & imem_ack; decode takes inst when
   // inst_valid & inst_ready; res_valid counts only in S_OUT with inst_ready, or in S_RES.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      retired_d = retired_q;
      err_d     = err_q;
      tcnt_d    = tcnt_q;
      resolve   = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_ack) begin
               inst_d    = imem_rdata;
               inst_pc_d = pc_q;
               tcnt_d    = '0;
               state_d   = S_OUT;
            end else if (tcnt_q == TCNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               tcnt_d  = '0;
               state_d = S_HALT;
            end else begin
               tcnt_d = tcnt_q + TCNT_W'(1);
            end
         end
         S_OUT: begin
            if (inst_ready) begin
               if (res_valid) resolve = 1'b1;
               else           state_d = S_RES;
            end
         end
         S_RES:   if (res_valid) resolve = 1'b1;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
      if (resolve) begin
         pc_d      = npc_w;
         retired_d = retired_q + CNT_W'(1);
         state_d   = res_halt ? S_HALT : S_REQ;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         inst_pc_q <= '0;
         retired_q <= '0;
         err_q     <= 1'b0;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         retired_q <= retired_d;
         err_q     <= err_d;
         tcnt_q    <= tcnt_d;
      end
   end

   assign imem_req   = (state_q == S_REQ);
   assign imem_addr  = pc_q;
   assign inst_valid = (state_q == S_OUT);
   assign inst       = inst_q;
   assign inst_pc    = inst_pc_q;
   assign halted     = (state_q == S_HALT);
   assign fetch_err  = err_q;
   assign retired    = retired_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: imem/decode driver tasks, fetched words checked through an expected queue.
module tb_fetch_seq;
  import fetch_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1, rst_b = 1'b1, sel = 1'b0;
  logic        imem_ack = 1'b0, inst_ready = 1'b0, res_valid = 1'b0;
  logic        res_branch = 1'b0, res_jmp = 1'b0, res_halt = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [15:0] res_imm16 = '0;
  logic [25:0] res_imm26 = '0;

  logic        req_a, req_b, iv_a, iv_b, hl_a, hl_b, er_a, er_b;
  logic [31:0] addr_a, addr_b, inst_a, inst_b, ipc_a, ipc_b, ret_a, ret_b;
  logic [2:0]  st_a, st_b;

  logic        imem_req, inst_valid, halted, fetch_err;
  logic [31:0] imem_addr, inst, inst_pc, retired;
  logic [2:0]  dbg_state;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_retired;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fetch_seq dut_a (
    .clk(clk), .rst(rst_a), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(iv_a), .inst_ready(inst_ready), .inst(inst_a),
    .inst_pc(ipc_a), .res_valid(res_valid), .res_branch(res_branch), .res_jmp(res_jmp),
    .res_imm16(res_imm16), .res_imm26(res_imm26), .res_halt(res_halt), .halted(hl_a),
    .fetch_err(er_a), .retired(ret_a), .dbg_state(st_a)
  );

  fetch_seq #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst(rst_b), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(iv_b), .inst_ready(inst_ready), .inst(inst_b),
    .inst_pc(ipc_b), .res_valid(res_valid), .res_branch(res_branch), .res_jmp(res_jmp),
    .res_imm16(res_imm16), .res_imm26(res_imm26), .res_halt(res_halt), .halted(hl_b),
    .fetch_err(er_b), .retired(ret_b), .dbg_state(st_b)
  );

  assign imem_req   = sel ? req_b  : req_a;
  assign imem_addr  = sel ? addr_b : addr_a;
  assign inst_valid = sel ? iv_b   : iv_a;
  assign inst       = sel ? inst_b : inst_a;
  assign inst_pc    = sel ? ipc_b  : ipc_a;
  assign halted     = sel ? hl_b   : hl_a;
  assign fetch_err  = sel ? er_b   : er_a;
  assign retired    = sel ? ret_b  : ret_a;
  assign dbg_state  = sel ? st_b   : st_a;

  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [15:0] i16,
                                            input logic [25:0] i26, input logic br, input logic j);
    logic [31:0] p4;
    p4 = pc + 32'd4;
    if (j) return {pc[31:28], i26, 2'b00};
    if (br) return p4 + {{14{i16[15]}}, i16, 2'b00};
    return p4;
  endfunction

  task automatic clear_res();
    res_valid = 1'b0; res_branch = 1'b0; res_jmp = 1'b0; res_halt = 1'b0;
    res_imm16 = '0; res_imm26 = '0;
  endtask

  // imem driver: wait for the request, check its address, ack after lat cycles.
  task automatic fetch_one(input logic [31:0] word, input int lat);
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++; $display("FAIL fetch_req_wait: imem_req=%b required 1", imem_req);
    end
    checks++;
    if (imem_addr !== exp_pc) begin
      errors++; $display("FAIL fetch_addr: imem_addr=%h required %h", imem_addr, exp_pc);
    end
    repeat (lat) @(negedge clk);
    imem_ack = 1'b1; imem_rdata = word;
    exp_q.push_back(word);
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = $urandom;
  endtask

  // Decode driver: accept the word, then deliver its resolution.
  task automatic resolve(input logic br, input logic j, input logic [15:0] i16,
                         input logic [25:0] i26, input logic hlt, input int rdy_dly, input int res_dly);
    logic [31:0] exp_w;
    int n = 0;
    while (inst_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (inst_valid !== 1'b1) begin
      errors++; $display("FAIL inst_valid_wait: inst_valid=%b required 1", inst_valid);
    end
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    checks++;
    if (inst !== exp_w) begin
      errors++; $display("FAIL inst_word: inst=%h required %h", inst, exp_w);
    end
    checks++;
    if (inst_pc !== exp_pc) begin
      errors++; $display("FAIL inst_pc: inst_pc=%h required %h", inst_pc, exp_pc);
    end
    repeat (rdy_dly) begin
      imem_ack = 1'b1; imem_rdata = $urandom;
      res_valid = 1'b1; res_jmp = 1'b1; res_imm26 = 26'($urandom);
      @(negedge clk);
      imem_ack = 1'b0; clear_res();
    end
    if (rdy_dly > 0) begin
      checks++;
      if (inst !== exp_w || inst_valid !== 1'b1 || retired !== exp_retired) begin
        errors++;
        $display("FAIL stray_ignored: inst=%h valid=%b retired=%0d required %h 1 %0d",
                 inst, inst_valid, retired, exp_w, exp_retired);
      end
    end
    inst_ready = 1'b1;
    if (res_dly == 0) begin
      res_valid = 1'b1; res_branch = br; res_jmp = j; res_imm16 = i16; res_imm26 = i26; res_halt = hlt;
    end
    @(negedge clk);
    inst_ready = 1'b0; clear_res();
    if (res_dly > 0) begin
      repeat (res_dly - 1) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        errors++; $display("FAIL one_in_flight: imem_req=%b inst_valid=%b required 0 0", imem_req, inst_valid);
      end
      res_valid = 1'b1; res_branch = br; res_jmp = j; res_imm16 = i16; res_imm26 = i26; res_halt = hlt;
      @(negedge clk);
      clear_res();
    end
    exp_pc = model_npc(exp_pc, i16, i26, br, j);
    exp_retired++;
    checks++;
    if (retired !== exp_retired) begin
      errors++; $display("FAIL retired: retired=%0d required %0d", retired, exp_retired);
    end
    checks++;
    if (imem_addr !== exp_pc || halted !== hlt || imem_req !== !hlt) begin
      errors++;
      $display("FAIL after_resolve: addr=%h halted=%b req=%b required %h %b %b",
               imem_addr, halted, imem_req, exp_pc, hlt, !hlt);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    exp_q.delete(); exp_pc = 32'h0000_3000; exp_retired = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || halted !== 1'b0 || fetch_err !== 1'b0 ||
        retired !== 32'd0 || inst !== 32'd0 || inst_pc !== 32'd0 || dbg_state !== 3'(S_IDLE)) begin
      errors++;
      $display("FAIL reset_state: req=%b iv=%b halt=%b err=%b ret=%0d inst=%h ipc=%h st=%0d required all zero",
               imem_req, inst_valid, halted, fetch_err, retired, inst, inst_pc, dbg_state);
    end
    rst_a = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL first_req: req=%b addr=%h required 1 00003000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    fetch_one(32'h2108_0001, 0);
    resolve(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 0, 0);
    checks++;
    if (imem_addr !== 32'h0000_3004 || retired !== 32'd1) begin
      errors++; $display("FAIL seq_advance: addr=%h retired=%0d required 00003004 1", imem_addr, retired);
    end
    fetch_one(32'h2108_0002, 3);
    resolve(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 1, 2);
  endtask

  task automatic test_branch();
    fetch_one(32'h1000_FFFF, 1);
    resolve(1'b1, 1'b0, 16'hFFFF, 26'h0, 1'b0, 0, 1);
    checks++;
    if (imem_addr !== 32'h0000_3008) begin
      errors++; $display("FAIL branch_back: addr=%h required 00003008", imem_addr);
    end
    fetch_one(32'h1000_0004, 0);
    resolve(1'b1, 1'b0, 16'h0004, 26'h0, 1'b0, 2, 0);
    checks++;
    if (imem_addr !== 32'h0000_301C) begin
      errors++; $display("FAIL branch_fwd: addr=%h required 0000301C", imem_addr);
    end
  endtask

  task automatic test_jump();
    fetch_one(32'h0800_0C00, 0);
    resolve(1'b0, 1'b1, 16'h0, 26'h000_0C00, 1'b0, 0, 0);
    checks++;
    if (imem_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL jump_to_3000: addr=%h required 00003000", imem_addr);
    end
    fetch_one(32'h0800_0100, 2);
    resolve(1'b1, 1'b1, 16'h0040, 26'h000_0100, 1'b0, 0, 1);
    checks++;
    if (imem_addr !== 32'h0000_0400) begin
      errors++; $display("FAIL jump_priority: addr=%h required 00000400", imem_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      fetch_one(32'($urandom), $urandom_range(0, 6));
      resolve(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 16'($urandom), 26'($urandom),
              1'b0, $urandom_range(0, 2), $urandom_range(0, 2));
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    while (imem_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    repeat (15) @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      errors++; $display("FAIL timeout_early: req=%b err=%b required 1 0", imem_req, fetch_err);
    end
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_req !== 1'b0 || dbg_state !== 3'(S_HALT)) begin
      errors++;
      $display("FAIL timeout_halt: err=%b halted=%b req=%b st=%0d required 1 1 0 %0d",
               fetch_err, halted, imem_req, dbg_state, S_HALT);
    end
    repeat (3) begin
      imem_ack = 1'b1; inst_ready = 1'b1; res_valid = 1'b1;
      @(negedge clk);
    end
    imem_ack = 1'b0; inst_ready = 1'b0; clear_res();
    checks++;
    if (fetch_err !== 1'b1 || halted !== 1'b1 || inst_valid !== 1'b0 || retired !== exp_retired) begin
      errors++;
      $display("FAIL halt_sticky: err=%b halted=%b iv=%b ret=%0d required 1 1 0 %0d",
               fetch_err, halted, inst_valid, retired, exp_retired);
    end
    rst_a = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0 || halted !== 1'b0 || retired !== 32'd0 || imem_addr !== 32'h0000_3000) begin
      errors++;
      $display("FAIL rst_clears: err=%b halted=%b ret=%0d addr=%h required 0 0 0 00003000",
               fetch_err, halted, retired, imem_addr);
    end
    rst_a = 1'b0;
  endtask

  task automatic test_wrap_halt();
    sel = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    exp_q.delete(); exp_pc = 32'hFFFF_FFFC; exp_retired = '0;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    fetch_one(32'h0000_0000, 0);
    resolve(1'b0, 1'b0, 16'h0, 26'h0, 1'b0, 0, 0);
    checks++;
    if (imem_addr !== 32'h0000_0000) begin
      errors++; $display("FAIL pc_wrap: addr=%h required 00000000", imem_addr);
    end
    fetch_one(32'h0000_000D, 1);
    resolve(1'b1, 1'b0, 16'h0002, 26'h0, 1'b1, 0, 1);
    checks++;
    if (halted !== 1'b1 || retired !== 32'd2 || imem_addr !== 32'h0000_000C || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL res_halt: halted=%b ret=%0d addr=%h req=%b required 1 2 0000000C 0",
               halted, retired, imem_addr, imem_req);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_random();
    test_timeout();
    test_wrap_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
